// File: rtl/fetch_discard_ctrl_pkg.sv
// Shared fetch-side definitions: the cpuDefine package that cpu.svh exposes to the core.
// Holds the FetchState encoding used by fetch_discard_ctrl and its bench.
package cpuDefine;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_BUSY  = 2'd1,
        FS_DRAIN = 2'd2
    } FetchState;

    localparam int PERF_W = 32;

endpackage

// File: rtl/fetch_discard_ctrl_sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
// Synchronous clear has priority over increment.
module sat_counter32
    import cpuDefine::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              inc_i,
    input  logic              clear_i,
    output logic [PERF_W-1:0] count_o
);

    logic [PERF_W-1:0] cnt_q;
    logic [PERF_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_discard_ctrl.sv
// Tracks in-flight instruction fetches and drops responses made stale by a redirect.
// Optional FETCH_DISCARD_PERF_EN adds a saturating count of discarded responses.
//
// Handshake: req_fire means the bus accepted a request this cycle; rsp_valid means
// one response returns this cycle, in request order. Each response with something
// in flight is either accepted or discarded, never both, in the same cycle.
module fetch_discard_ctrl
    import cpuDefine::*;
#(
    parameter  int MAX_OUT = 2,
    localparam int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic             aclk,
    input  logic             resetn,
    input  logic             req_fire,
    input  logic             rsp_valid,
    input  logic             kill,
    output logic             rsp_accept,
    output logic             rsp_discard,
    output logic             req_block,
    output FetchState        state,
    output logic [CNT_W-1:0] out_cnt,
    output logic             protocol_err
`ifdef FETCH_DISCARD_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_discard_cnt
`endif
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    logic [CNT_W-1:0] out_q, out_d;
    logic [CNT_W-1:0] disc_q, disc_d;
    logic             err_q, err_d;
    FetchState        state_q, state_d;

    logic full;
    logic rsp_live;
    logic rsp_stale;
    logic fire_ovf;
    logic fire_ok;

    // A response with nothing outstanding is a protocol error, not a discard.
    always_comb begin
        full      = (out_q == MAX_CNT);
        rsp_live  = rsp_valid && (out_q != '0);
        rsp_stale = rsp_live && (kill || (disc_q != '0));
        fire_ovf  = req_fire && full && !rsp_valid;
        fire_ok   = req_fire && !fire_ovf;

        rsp_discard = resetn && rsp_stale;
        rsp_accept  = resetn && rsp_live && !rsp_stale;
        req_block   = full && !rsp_valid;

        out_d = out_q + CNT_W'(fire_ok) - CNT_W'(rsp_live);
        err_d = err_q || (rsp_valid && (out_q == '0)) || fire_ovf;

        disc_d = disc_q;
        if (kill) begin
            disc_d = out_d;
        end else if (rsp_stale) begin
            disc_d = disc_q - CNT_W'(1);
        end

        state_d = FS_IDLE;
        if (disc_d != '0) begin
            state_d = FS_DRAIN;
        end else if (out_d != '0) begin
            state_d = FS_BUSY;
        end
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            out_q   <= '0;
            disc_q  <= '0;
            err_q   <= 1'b0;
            state_q <= FS_IDLE;
        end else begin
            out_q   <= out_d;
            disc_q  <= disc_d;
            err_q   <= err_d;
            state_q <= state_d;
        end
    end

    assign state        = state_q;
    assign out_cnt      = out_q;
    assign protocol_err = err_q;

`ifdef FETCH_DISCARD_PERF_EN
    sat_counter32 u_perf (
        .clk_i   (aclk),
        .rst_ni  (resetn),
        .inc_i   (rsp_discard),
        .clear_i (1'b0),
        .count_o (perf_discard_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_discard_ctrl.sv
// Bench for fetch_discard_ctrl: directed vector table, reset/perf sequences,
// then random traffic against a queue-of-requests reference model.
module tb_fetch_discard_ctrl;
    import cpuDefine::*;

    localparam int MAX   = 2;
    localparam int CNT_W = $clog2(MAX + 1);

    logic             aclk = 1'b0;
    logic             resetn = 1'b0;
    logic             req_fire = 1'b0;
    logic             rsp_valid = 1'b0;
    logic             kill = 1'b0;
    logic             rsp_accept;
    logic             rsp_discard;
    logic             req_block;
    FetchState        state;
    logic [CNT_W-1:0] out_cnt;
    logic             protocol_err;
`ifdef FETCH_DISCARD_PERF_EN
    logic [31:0]      perf_discard_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 aclk = ~aclk;

    fetch_discard_ctrl #(.MAX_OUT(MAX)) dut (
        .aclk         (aclk),
        .resetn       (resetn),
        .req_fire     (req_fire),
        .rsp_valid    (rsp_valid),
        .kill         (kill),
        .rsp_accept   (rsp_accept),
        .rsp_discard  (rsp_discard),
        .req_block    (req_block),
        .state        (state),
        .out_cnt      (out_cnt),
        .protocol_err (protocol_err)
`ifdef FETCH_DISCARD_PERF_EN
        ,
        .perf_discard_cnt (perf_discard_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic f, input logic r, input logic k);
        @(negedge aclk);
        req_fire  = f;
        rsp_valid = r;
        kill      = k;
        #1;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        resetn = 1'b0; req_fire = 1'b0; rsp_valid = 1'b0; kill = 1'b0;
        @(negedge aclk);
        resetn = 1'b1;
    endtask

    typedef struct {
        logic f, r, k;
        logic acc, dis, blk, err;
        int   out, disc;
        FetchState st;
    } vec_t;

    vec_t vecs[26];

    function automatic vec_t mk(logic f, logic r, logic k, logic acc, logic dis,
                                logic blk, logic err, int out, int disc, FetchState st);
        vec_t v;
        v.f = f; v.r = r; v.k = k; v.acc = acc; v.dis = dis; v.blk = blk;
        v.err = err; v.out = out; v.disc = disc; v.st = st;
        return v;
    endfunction

    // Reference model: one entry per outstanding request, 1 = stale.
    bit m_q[$];
    bit m_err;

    function automatic int m_stale_cnt();
        int n = 0;
        foreach (m_q[i]) n += int'(m_q[i]);
        return n;
    endfunction

    initial begin
        // f r k | acc dis blk err | out disc state  (registered fields are pre-edge)
        vecs[0]  = mk(0,0,0, 0,0,0,0, 0,0,FS_IDLE);
        vecs[1]  = mk(1,0,0, 0,0,0,0, 0,0,FS_IDLE);
        vecs[2]  = mk(0,0,0, 0,0,0,0, 1,0,FS_BUSY);
        vecs[3]  = mk(0,1,0, 1,0,0,0, 1,0,FS_BUSY);
        vecs[4]  = mk(0,0,0, 0,0,0,0, 0,0,FS_IDLE);
        vecs[5]  = mk(1,0,0, 0,0,0,0, 0,0,FS_IDLE);
        vecs[6]  = mk(1,0,0, 0,0,0,0, 1,0,FS_BUSY);
        vecs[7]  = mk(0,0,1, 0,0,1,0, 2,0,FS_BUSY);
        vecs[8]  = mk(0,1,0, 0,1,0,0, 2,2,FS_DRAIN);
        vecs[9]  = mk(1,0,0, 0,0,0,0, 1,1,FS_DRAIN);
        vecs[10] = mk(0,1,0, 0,1,0,0, 2,1,FS_DRAIN);
        vecs[11] = mk(0,1,0, 1,0,0,0, 1,0,FS_BUSY);
        vecs[12] = mk(0,0,0, 0,0,0,0, 0,0,FS_IDLE);
        vecs[13] = mk(1,0,0, 0,0,0,0, 0,0,FS_IDLE);
        vecs[14] = mk(1,1,1, 0,1,0,0, 1,0,FS_BUSY);
        vecs[15] = mk(0,0,0, 0,0,0,0, 1,1,FS_DRAIN);
        vecs[16] = mk(0,1,0, 0,1,0,0, 1,1,FS_DRAIN);
        vecs[17] = mk(0,0,0, 0,0,0,0, 0,0,FS_IDLE);
        vecs[18] = mk(1,0,0, 0,0,0,0, 0,0,FS_IDLE);
        vecs[19] = mk(1,0,0, 0,0,0,0, 1,0,FS_BUSY);
        vecs[20] = mk(0,0,0, 0,0,1,0, 2,0,FS_BUSY);
        vecs[21] = mk(0,1,0, 1,0,0,0, 2,0,FS_BUSY);
        vecs[22] = mk(0,1,0, 1,0,0,0, 1,0,FS_BUSY);
        vecs[23] = mk(0,1,0, 0,0,0,0, 0,0,FS_IDLE);
        vecs[24] = mk(0,0,1, 0,0,0,1, 0,0,FS_IDLE);
        vecs[25] = mk(0,0,0, 0,0,0,1, 0,0,FS_IDLE);

        #1;
        chk("rst_out", 32'(out_cnt), 0);
        chk("rst_state", 32'(state), 32'(FS_IDLE));
        chk("rst_err", 32'(protocol_err), 0);
        do_reset();

        for (int i = 0; i < 26; i++) begin
            drive(vecs[i].f, vecs[i].r, vecs[i].k);
            chk($sformatf("v%0d_acc", i), 32'(rsp_accept), 32'(vecs[i].acc));
            chk($sformatf("v%0d_dis", i), 32'(rsp_discard), 32'(vecs[i].dis));
            chk($sformatf("v%0d_blk", i), 32'(req_block), 32'(vecs[i].blk));
            chk($sformatf("v%0d_err", i), 32'(protocol_err), 32'(vecs[i].err));
            chk($sformatf("v%0d_out", i), 32'(out_cnt), 32'(vecs[i].out));
            chk($sformatf("v%0d_disc", i), 32'(dut.disc_q), 32'(vecs[i].disc));
            chk($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].st));
        end

        // Reset in the middle of a drain takes effect without a clock edge.
        do_reset();
        drive(1, 0, 0);
        drive(1, 0, 0);
        drive(0, 0, 1);
        drive(0, 0, 0);
        chk("mid_drain_disc", 32'(dut.disc_q), 2);
        chk("mid_drain_state", 32'(state), 32'(FS_DRAIN));
        rsp_valid = 1'b1;
        resetn = 1'b0;
        #1;
        chk("arst_out", 32'(out_cnt), 0);
        chk("arst_disc", 32'(dut.disc_q), 0);
        chk("arst_state", 32'(state), 32'(FS_IDLE));
        chk("arst_dis", 32'(rsp_discard), 0);
        chk("arst_acc", 32'(rsp_accept), 0);
        do_reset();

`ifdef FETCH_DISCARD_PERF_EN
        drive(1, 0, 0);
        drive(1, 0, 0);
        drive(0, 0, 1);
        drive(0, 1, 0);
        drive(1, 1, 0);
        drive(0, 1, 1);
        drive(0, 0, 0);
        chk("perf_three", perf_discard_cnt, 32'd3);
        force dut.u_perf.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.u_perf.cnt_q;
        drive(1, 0, 0);
        drive(0, 1, 1);
        drive(0, 0, 0);
        chk("perf_sat", perf_discard_cnt, 32'hFFFF_FFFF);
        do_reset();
`endif

        // Random traffic; responses only while something is outstanding.
        m_q.delete();
        m_err = 0;
        for (int c = 0; c < 3000; c++) begin
            logic f, r, k;
            int cnt;
            logic e_dis, e_acc;
            cnt = m_q.size();
            f = ($urandom_range(0, 99) < 55);
            r = (cnt > 0) && ($urandom_range(0, 99) < 45);
            k = ($urandom_range(0, 99) < 10);
            drive(f, r, k);

            e_dis = r && (cnt > 0) && (k || m_q[0]);
            e_acc = r && (cnt > 0) && !e_dis;
            chk("rnd_acc", 32'(rsp_accept), 32'(e_acc));
            chk("rnd_dis", 32'(rsp_discard), 32'(e_dis));
            chk("rnd_blk", 32'(req_block), 32'((cnt == MAX) && !r));
            chk("rnd_out", 32'(out_cnt), 32'(cnt));
            chk("rnd_disc", 32'(dut.disc_q), 32'(m_stale_cnt()));
            chk("rnd_err", 32'(protocol_err), 32'(m_err));
            chk("rnd_state", 32'(state),
                (m_stale_cnt() > 0) ? 32'(FS_DRAIN) : (cnt > 0) ? 32'(FS_BUSY) : 32'(FS_IDLE));

            if (r) void'(m_q.pop_front());
            if (f) begin
                if (cnt == MAX && !r) m_err = 1;
                else m_q.push_back(1'b0);
            end
            if (k) foreach (m_q[i]) m_q[i] = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_discard_ctrl.md
FETCH_DISCARD_CTRL -- requirements
Module: fetch_discard_ctrl

Interface
REQ-001 SHALL have parameter MAX_OUT, default 2: max in-flight instruction-fetch requests, range 1..7.
REQ-002 SHALL have port aclk, input, 1: the single clock; all state updates on rising edge.
REQ-003 SHALL have port resetn, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port req_fire, input, 1: a fetch request was accepted by the bus this cycle (req && addr_ok).
REQ-005 SHALL have port rsp_valid, input, 1: a fetch response (data_ok) returns this cycle.
REQ-006 SHALL have port kill, input, 1: redirect or flush (branch taken, exception, ertn, refetch) this cycle.
REQ-007 SHALL have port rsp_accept, output, 1: the current response goes to the IF stage.
REQ-008 SHALL have port rsp_discard, output, 1: the current response is stale and is dropped.
REQ-009 SHALL have port req_block, output, 1: IF shall not issue a new request.
REQ-010 SHALL have port state, output, FetchState: current FSM state.
REQ-011 SHALL have port out_cnt, output, CNT_W: in-flight count; CNT_W = $clog2(MAX_OUT+1).
REQ-012 SHALL have port protocol_err, output, 1: sticky flag for a response with nothing in flight.

Function
REQ-013 SHALL hold registers out_cnt and disc_cnt (stale responses still owed), both CNT_W wide.
REQ-014 SHALL update out_cnt as out_cnt + req_fire - (rsp_valid && out_cnt!=0) each cycle, so a simultaneous fire and response leaves it unchanged.
REQ-015 SHALL drive rsp_discard = rsp_valid && (kill || disc_cnt!=0); purely combinational, zero latency.
REQ-016 SHALL drive rsp_accept = rsp_valid && !rsp_discard && out_cnt!=0; the two are never both 1.
REQ-017 SHALL set disc_cnt_next to the next out_cnt on a kill cycle, so every in-flight request is marked stale, including one fired in the same cycle.
REQ-018 SHALL, without kill, decrement disc_cnt by 1 on each discarded response and otherwise hold it.
REQ-019 SHALL drive req_block = (out_cnt == MAX_OUT) && !rsp_valid, registered count only; kill does not block issue.
REQ-020 SHALL ignore req_fire while out_cnt==MAX_OUT and no response returns: no increment, and protocol_err is set.
REQ-021 SHALL, on rsp_valid with out_cnt==0, assert neither rsp_accept nor rsp_discard, leave all counts unchanged, and set protocol_err.
REQ-022 SHALL use a FSM with states FS_IDLE (out=0), FS_BUSY (out>0, disc=0) and FS_DRAIN (disc>0), computed from the next counter values and registered.
REQ-023 SHALL transition as follows:
  - IDLE->BUSY on fire.
  - BUSY->DRAIN on kill with a nonzero next out_cnt.
  - DRAIN->BUSY or DRAIN->IDLE when disc reaches 0.
  - A kill in DRAIN re-marks all in-flight requests per REQ-017.
REQ-024 SHALL keep the invariant disc_cnt <= out_cnt every cycle.

Reset
REQ-025 SHALL, with resetn low, asynchronously clear out_cnt, disc_cnt and protocol_err, set state to FS_IDLE, and force rsp_accept and rsp_discard to 0.
REQ-026 SHALL, on reset in mid-drain, abandon the drain with no discard state retained; the bus is reset by the same resetn.

Configuration
REQ-027 SHALL, with macro FETCH_DISCARD_PERF_EN defined, add output perf_discard_cnt (32 bits), a saturating count of rsp_discard cycles, reset to 0.
REQ-028 SHALL, with FETCH_DISCARD_PERF_EN undefined, omit both that port and the counter.

Structure
REQ-029 SHALL define the FetchState enum (FS_IDLE=0, FS_BUSY=1, FS_DRAIN=2, 2 bits) in package cpuDefine via cpu.svh.
REQ-030 SHALL place the perf counter in one sub-module, sat_counter32 (inc, clear, 32-bit saturating output).

Verification
REQ-031 SHALL cover basic flow: fire at cycle 1, response at cycle 3 -> rsp_accept=1 at cycle 3; out_cnt goes 0,1,1,0; state goes IDLE, BUSY, IDLE.
REQ-032 SHALL cover kill with 2 in flight: two fires, kill with no response -> disc_cnt=2; the next two responses discarded and the third accepted; state goes DRAIN->BUSY->IDLE.
REQ-033 SHALL cover the simultaneous edge: kill, fire and response in one cycle with out_cnt=1 -> response discarded; out_cnt=1 and disc_cnt=1 next cycle.
REQ-034 SHALL cover full and protocol errors:
  - MAX_OUT=2, two fires -> req_block=1.
  - A response in the same cycle -> req_block=0.
  - A response with out_cnt=0 -> protocol_err=1, stays set until reset.
REQ-035 SHALL cover reset mid-drain: resetn low while disc_cnt=2 -> all counts 0 and FS_IDLE immediately, without waiting for a clock edge.
REQ-036 SHALL cover the perf counter: with FETCH_DISCARD_PERF_EN defined, 3 discards -> perf_discard_cnt=3; a preload of 0xFFFFFFFF stays at 0xFFFFFFFF after a further discard.
